// File: rtl/timed_value_checker_pkg.sv
// Shared definitions for the timed value checker: FSM encodings and default widths.
package timed_value_checker_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NCHK  = 4;
  localparam int unsigned DEF_TW    = 8;
  localparam int unsigned DEF_PW    = 8;
  localparam int unsigned DEF_FW    = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/timed_value_checker_if.sv
// Configuration, observation and result bus of the timed value checker.
interface timed_value_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCHK  = 4,
  parameter int unsigned TW    = 8,
  parameter int unsigned PW    = 8,
  parameter int unsigned FW    = 8
);
  localparam int unsigned IW = (NCHK > 1) ? $clog2(NCHK) : 1;

  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic             cfg_en;
  logic [TW-1:0]    cfg_offset;
  logic [WIDTH-1:0] cfg_expect;
  logic [TW-1:0]    period;
  logic [PW-1:0]    num_periods;
  logic             start;
  logic [WIDTH-1:0] obs_value;

  logic             busy;
  logic             done;
  logic             pass;
  logic             err_pulse;
  logic [FW-1:0]    fail_count;
  logic [IW-1:0]    fail_slot;
  logic [WIDTH-1:0] fail_value;
  logic [PW-1:0]    fail_period;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_offset, cfg_expect,
    output period, num_periods, start, obs_value,
    input  busy, done, pass, err_pulse, fail_count, fail_slot, fail_value, fail_period
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_offset, cfg_expect,
    input  period, num_periods, start, obs_value,
    output busy, done, pass, err_pulse, fail_count, fail_slot, fail_value, fail_period
  );
endinterface

// File: rtl/timed_value_checker_checkpoint_table.sv
// Checkpoint register file with parallel offset match and value compare per slot.
module timed_value_checker_checkpoint_table #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCHK  = 4,
  parameter int unsigned TW    = 8,
  parameter int unsigned IW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic             en,
  input  logic [TW-1:0]    offset,
  input  logic [WIDTH-1:0] exp_val,
  input  logic             check_en,
  input  logic [TW-1:0]    t,
  input  logic [WIDTH-1:0] obs_value,
  output logic [NCHK-1:0]  mismatch_c
);

  logic [NCHK-1:0]  slot_en;
  logic [TW-1:0]    slot_off [NCHK];
  logic [WIDTH-1:0] slot_exp [NCHK];
  logic             idx_ok;

  assign idx_ok = ({1'b0, idx} < (IW+1)'(NCHK));

  // Slot storage; out-of-range indices are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_en <= '0;
      for (int i = 0; i < NCHK; i++) begin
        slot_off[i] <= '0;
        slot_exp[i] <= '0;
      end
    end else if (we && idx_ok) begin
      slot_en[idx]  <= en;
      slot_off[idx] <= offset;
      slot_exp[idx] <= exp_val;
    end
  end

  // t never reaches period, so offsets beyond the period simply never match
  always_comb begin
    mismatch_c = '0;
    for (int i = 0; i < NCHK; i++) begin
      mismatch_c[i] = check_en && slot_en[i] && (slot_off[i] == t) && (slot_exp[i] != obs_value);
    end
  end

endmodule

// File: rtl/timed_value_checker.sv
// Timed value checker: samples obs_value at programmed offsets of a repeating period
// and records mismatch count plus first-failure details.
module timed_value_checker
  import timed_value_checker_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCHK  = DEF_NCHK,
  parameter int unsigned TW    = DEF_TW,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned FW    = DEF_FW
) (
  input logic                clk,
  input logic                reset_n,
  timed_value_checker_if.slave bus
);

  localparam int unsigned IW = (NCHK > 1) ? $clog2(NCHK) : 1;

  logic [1:0]       state_q, state_nx;
  logic [TW-1:0]    t_q, t_nx;
  logic [PW-1:0]    p_q, p_nx;
  logic [TW-1:0]    per_q, per_nx;
  logic [PW-1:0]    np_q, np_nx;
  logic [FW-1:0]    fc_q, fc_nx;
  logic [IW-1:0]    fslot_q, fslot_nx;
  logic [WIDTH-1:0] fval_q, fval_nx;
  logic [PW-1:0]    fper_q, fper_nx;
  logic             err_q, err_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             pass_q, pass_nx;
  logic             table_we;
  logic [NCHK-1:0]  mismatch_c;

  // Table is frozen while a run is in progress
  assign table_we = bus.cfg_we && (state_q != ST_RUN);

  timed_value_checker_checkpoint_table #(
    .WIDTH (WIDTH),
    .NCHK  (NCHK),
    .TW    (TW),
    .IW    (IW)
  ) u_table (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (table_we),
    .idx        (bus.cfg_idx),
    .en         (bus.cfg_en),
    .offset     (bus.cfg_offset),
    .exp_val    (bus.cfg_expect),
    .check_en   (state_q == ST_RUN),
    .t          (t_q),
    .obs_value  (bus.obs_value),
    .mismatch_c (mismatch_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      p_q     <= '0;
      per_q   <= '0;
      np_q    <= '0;
      fc_q    <= '0;
      fslot_q <= '0;
      fval_q  <= '0;
      fper_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      t_q     <= t_nx;
      p_q     <= p_nx;
      per_q   <= per_nx;
      np_q    <= np_nx;
      fc_q    <= fc_nx;
      fslot_q <= fslot_nx;
      fval_q  <= fval_nx;
      fper_q  <= fper_nx;
      err_q   <= err_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      pass_q  <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    t_nx     = t_q;
    p_nx     = p_q;
    per_nx   = per_q;
    np_nx    = np_q;
    fc_nx    = fc_q;
    fslot_nx = fslot_q;
    fval_nx  = fval_q;
    fper_nx  = fper_q;
    err_nx   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (|mismatch_c) begin
          err_nx = 1'b1;
          for (int i = 0; i < NCHK; i++) begin
            if (mismatch_c[i] && (fc_nx != '1)) fc_nx = fc_nx + FW'(1);
          end
          // First failure of the run: descending scan leaves the lowest index
          if (fc_q == '0) begin
            fval_nx = bus.obs_value;
            fper_nx = p_q;
            for (int i = NCHK - 1; i >= 0; i--) begin
              if (mismatch_c[i]) fslot_nx = IW'(i);
            end
          end
        end
        if (t_q == per_q - TW'(1)) begin
          t_nx = '0;
          if (p_q == np_q - PW'(1)) state_nx = ST_DONE;
          else                       p_nx     = p_q + PW'(1);
        end else begin
          t_nx = t_q + TW'(1);
        end
      end
      default: begin
        if (bus.start) begin
          per_nx   = bus.period;
          np_nx    = bus.num_periods;
          t_nx     = '0;
          p_nx     = '0;
          fc_nx    = '0;
          fslot_nx = '0;
          fval_nx  = '0;
          fper_nx  = '0;
          state_nx = ((bus.period == '0) || (bus.num_periods == '0)) ? ST_DONE : ST_RUN;
        end
      end
    endcase

    busy_nx = (state_nx == ST_RUN);
    done_nx = (state_nx == ST_DONE);
    pass_nx = done_nx && (fc_nx == '0);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.err_pulse   = err_q;
  assign bus.fail_count  = fc_q;
  assign bus.fail_slot   = fslot_q;
  assign bus.fail_value  = fval_q;
  assign bus.fail_period = fper_q;

endmodule

// File: tb/tb_timed_value_checker.sv
// Scoreboard bench for timed_value_checker: a reference model predicts each run's
// result, a monitor compares when done rises.
module tb_timed_value_checker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NCHK  = 4;
  localparam int unsigned TW    = 8;
  localparam int unsigned PW    = 8;
  localparam int unsigned FW    = 8;
  localparam int unsigned IW    = 2;
  localparam int FC_MAX = (1 << FW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  timed_value_checker_if #(.WIDTH(WIDTH), .NCHK(NCHK), .TW(TW), .PW(PW), .FW(FW)) bus();

  timed_value_checker #(.WIDTH(WIDTH), .NCHK(NCHK), .TW(TW), .PW(PW), .FW(FW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int fc;
    int slot;
    int value;
    int per;
    int pass;
    int nerr;
  } result_t;

  result_t exp_q[$];
  result_t mon_e;
  int      vectors = 0;
  int      miscompares = 0;
  int      err_seen = 0;
  bit      done_prev = 1'b0;

  bit      m_en  [NCHK];
  int      m_off [NCHK];
  int      m_exp [NCHK];
  int      obs_seq[$];

  task automatic check(input string name, input logic [31:0] act, input int req);
    vectors++;
    if (act !== 32'(req)) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: walk every run cycle, find enabled slots whose offset equals the phase
  function automatic result_t model(input int per, input int np);
    result_t r;
    r.fc = 0; r.slot = 0; r.value = 0; r.per = 0; r.pass = 1; r.nerr = 0;
    for (int k = 0; k < per * np; k++) begin
      int t = k % per;
      int p = k / per;
      int nm = 0;
      int low = -1;
      for (int i = 0; i < NCHK; i++) begin
        if (m_en[i] && m_off[i] == t && m_exp[i] != obs_seq[k]) begin
          nm++;
          if (low < 0) low = i;
        end
      end
      if (nm > 0) begin
        r.nerr++;
        if (r.fc == 0) begin
          r.slot = low; r.value = obs_seq[k]; r.per = p;
        end
        r.fc = (r.fc + nm > FC_MAX) ? FC_MAX : r.fc + nm;
      end
    end
    r.pass = (r.fc == 0) ? 1 : 0;
    return r;
  endfunction

  // Monitor: counts error strobes and scores each completed run
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        err_seen  = 0;
        done_prev = 1'b0;
      end else begin
        if (bus.err_pulse) err_seen++;
        if (!bus.done) check("pass_without_done", 32'(bus.pass), 0);
        if (bus.done && !done_prev) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("fail_count",  32'(bus.fail_count),  mon_e.fc);
            check("fail_slot",   32'(bus.fail_slot),   mon_e.slot);
            check("fail_value",  32'(bus.fail_value),  mon_e.value);
            check("fail_period", 32'(bus.fail_period), mon_e.per);
            check("pass",        32'(bus.pass),        mon_e.pass);
            check("err_pulses",  32'(err_seen),        mon_e.nerr);
          end
          err_seen = 0;
        end
        done_prev = bus.done;
      end
    end
  end

  task automatic cfg_write(input int idx, input bit en, input int off, input int ev);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = IW'(idx);
    bus.cfg_en     = en;
    bus.cfg_offset = TW'(off);
    bus.cfg_expect = WIDTH'(ev);
    if (idx < NCHK) begin
      m_en[idx] = en; m_off[idx] = off; m_exp[idx] = ev;
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // One run; meddle pokes cfg_we/start mid-run, abort_at >= 0 resets at that run cycle
  task automatic run(input int per, input int np, input bit meddle, input int abort_at);
    int  len = per * np;
    int  cyc = 0;
    if (abort_at < 0) exp_q.push_back(model(per, np));
    @(negedge clk);
    bus.period      = TW'(per);
    bus.num_periods = PW'(np);
    bus.start       = 1'b1;
    while (cyc < len + 5) begin
      @(negedge clk);
      cyc++;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      if (bus.done) break;
      if (abort_at >= 0 && cyc - 1 == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy",       32'(bus.busy),       0);
        check("abort_done",       32'(bus.done),       0);
        check("abort_fail_count", 32'(bus.fail_count), 0);
        check("abort_fail_slot",  32'(bus.fail_slot),  0);
        check("abort_err_pulse",  32'(bus.err_pulse),  0);
        for (int i = 0; i < NCHK; i++) begin
          m_en[i] = 1'b0; m_off[i] = 0; m_exp[i] = 0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (cyc - 1 < len) bus.obs_value = WIDTH'(obs_seq[cyc - 1]);
      if (meddle && cyc == 3) begin
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = IW'(2);
        bus.cfg_en     = 1'b1;
        bus.cfg_offset = TW'(3);
        bus.cfg_expect = WIDTH'(15);
        bus.start      = 1'b1;
      end
    end
    check("done_latency", 32'(cyc), len + 1);
  endtask

  task automatic plan_table();
    cfg_write(0, 1'b1, 4, 0);
    cfg_write(1, 1'b1, 6, 1);
    cfg_write(2, 1'b0, 11, 9);
    cfg_write(3, 1'b0, 0, 0);
  endtask

  task automatic obs_step(input int per, input int np);
    obs_seq.delete();
    for (int k = 0; k < per * np; k++) obs_seq.push_back(((k % per) < 5) ? 0 : 1);
  endtask

  task automatic obs_const(input int n, input int v);
    obs_seq.delete();
    for (int k = 0; k < n; k++) obs_seq.push_back(v);
  endtask

  task automatic obs_rand(input int n);
    obs_seq.delete();
    for (int k = 0; k < n; k++) obs_seq.push_back(int'($urandom_range(0, 3)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0; bus.cfg_offset = '0;
    bus.cfg_expect = '0; bus.period = '0; bus.num_periods = '0; bus.start = 1'b0;
    bus.obs_value = '0;
    for (int i = 0; i < NCHK; i++) begin
      m_en[i] = 1'b0; m_off[i] = 0; m_exp[i] = 0;
    end

    #12;
    check("rst_busy",        32'(bus.busy),        0);
    check("rst_done",        32'(bus.done),        0);
    check("rst_pass",        32'(bus.pass),        0);
    check("rst_err_pulse",   32'(bus.err_pulse),   0);
    check("rst_fail_count",  32'(bus.fail_count),  0);
    check("rst_fail_slot",   32'(bus.fail_slot),   0);
    check("rst_fail_value",  32'(bus.fail_value),  0);
    check("rst_fail_period", 32'(bus.fail_period), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Zero-length run straight out of IDLE
    obs_seq.delete();
    run(0, 3, 1'b0, -1);

    // Matching schedule; cfg_we and start mid-run must be ignored
    plan_table();
    obs_step(10, 2);
    run(10, 2, 1'b1, -1);

    // Same table, obs stuck at 0: offset-6 slot misses in both periods
    obs_const(20, 0);
    run(10, 2, 1'b0, -1);

    // Two slots fire together at the same offset
    cfg_write(0, 1'b1, 3, 5);
    cfg_write(1, 1'b0, 0, 0);
    cfg_write(2, 1'b1, 3, 5);
    cfg_write(3, 1'b0, 0, 0);
    obs_const(5, 7);
    run(5, 1, 1'b0, -1);

    // Counter saturation: four mismatches every cycle for 70 cycles
    for (int i = 0; i < NCHK; i++) cfg_write(i, 1'b1, 0, 1);
    obs_const(70, 0);
    run(1, 70, 1'b0, -1);

    // Randomized tables, periods and observations
    for (int n = 0; n < 20; n++) begin
      int per = int'($urandom_range(1, 12));
      int np  = int'($urandom_range(1, 4));
      for (int i = 0; i < NCHK; i++)
        cfg_write(i, 1'(($urandom_range(0, 3)) != 0), int'($urandom_range(0, per + 2)),
                  int'($urandom_range(0, 3)));
      obs_rand(per * np);
      run(per, np, 1'b0, -1);
    end

    // Reset at t=5 of period 1, then a run on the cleared table, then a clean rerun
    plan_table();
    obs_const(20, 0);
    run(10, 2, 1'b0, 15);
    obs_rand(5);
    run(5, 1, 1'b0, -1);
    plan_table();
    obs_step(10, 2);
    run(10, 2, 1'b0, -1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
